// File: rtl/nes_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nes_bus_arbiter
//
// Purpose:
//   N-master arbiter for the CPU memory bus (PRG / WRAM / PPU register space).
//   Masters such as the CPU, a debug host or a DMA engine each raise a request
//   and hold it until they receive an acknowledge. One winner owns the shared
//   bus for one whole transaction:
//     IDLE -> ACCESS (one bus_en strobe) -> WAIT (RD_LAT cycles) -> ACK -> IDLE
//   Read data comes back from the slave a fixed RD_LAT cycles after the strobe.
//   It is registered and handed to the owner in its ack cycle.
//   Arbitration is either fixed priority (lowest index wins) or round-robin.
//   A per-master lock lets one master, for example a debug session, keep
//   exclusive use of the bus across several transactions.
//
// Parameters:
//   NUM_MASTERS  number of requesting masters (1..8)
//   AW / DW      address / data width
//   RD_LAT       slave read latency, bus_en cycle to bus_din valid (1..4)
//   ARB_MODE     0 = fixed priority, 1 = round-robin
//
// Ports:
//   clk_in    in   system clock
//   rst_in    in   synchronous reset, active high; aborts any transaction
//   m_req     in   per-master request, held until m_ack
//   m_lock    in   per-master bus lock request
//   m_a       in   packed addresses, master i at [i*AW +: AW]
//   m_r_nw    in   per-master read(1) / write(0)
//   m_dout    in   packed write data, master i at [i*DW +: DW]
//   m_gnt     out  one-hot current owner, zero when idle
//   m_ack     out  one-cycle completion pulse to the owner
//   m_din     out  registered read data, valid in the m_ack cycle
//   bus_en    out  shared bus strobe, one cycle per transaction
//   bus_a     out  shared bus address (held for the whole transaction)
//   bus_r_nw  out  shared bus read/write (held for the whole transaction)
//   bus_dout  out  shared bus write data (held for the whole transaction)
//   bus_din   in   OR-combined slave read data
// -----------------------------------------------------------------------------
module nes_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int RD_LAT      = 1,
    parameter int ARB_MODE    = 0
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS-1:0]    m_lock,
    input  logic [NUM_MASTERS*AW-1:0] m_a,
    input  logic [NUM_MASTERS-1:0]    m_r_nw,
    input  logic [NUM_MASTERS*DW-1:0] m_dout,
    output logic [NUM_MASTERS-1:0]    m_gnt,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic [DW-1:0]             m_din,
    output logic                      bus_en,
    output logic [AW-1:0]             bus_a,
    output logic                      bus_r_nw,
    output logic [DW-1:0]             bus_dout,
    input  logic [DW-1:0]             bus_din
);

    // Master index width. It is kept at least one bit wide so that the
    // single-master build still has legal vectors.
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    // The wait counter runs from 0 to RD_LAT-1, and RD_LAT is at most 4.
    localparam int CW = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [IW-1:0]           owner;       // master that owns the current transaction
    logic [IW-1:0]           rr_ptr;      // round-robin search start (last winner + 1)
    logic                    lock_valid;  // a lock owner is recorded
    logic [IW-1:0]           lock_owner;
    logic [CW-1:0]           wait_cnt;

    logic [NUM_MASTERS-1:0]  owner_oh;
    logic [NUM_MASTERS-1:0]  lock_oh;
    logic                    lock_active;
    logic [NUM_MASTERS-1:0]  eligible;
    logic                    found;
    logic [IW-1:0]           winner;
    logic [AW-1:0]           sel_a;
    logic                    sel_r_nw;
    logic [DW-1:0]           sel_dout;
    logic                    wait_done;

    // -------------------------------------------------------------------------
    // Index decode: one-hot forms of the owner and the lock owner.
    // These use constant-index loops, so no variable bit-select lands on a
    // one-bit vector when NUM_MASTERS is 1.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        owner_oh = '0;
        lock_oh  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            owner_oh[i] = (owner == IW'(i));
            lock_oh[i]  = (lock_owner == IW'(i));
        end
    end

    // The lock only restricts eligibility while its owner still asserts
    // m_lock. The IDLE cycle in which the owner drops the lock is therefore
    // already open to every master. In the same cycle the stored lock is
    // cleared.
    assign lock_active = lock_valid && |(lock_oh & m_lock);

    // -------------------------------------------------------------------------
    // Winner selection.
    // Pass 1 takes the lowest eligible index at or above rr_ptr. In fixed
    // mode it simply takes the lowest eligible index. Pass 2 handles the
    // round-robin wrap back to index 0.
    // -------------------------------------------------------------------------
    always_comb begin
        eligible = m_req;
        if (lock_active) begin
            eligible = m_req & lock_oh;
        end

        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && eligible[i] && (ARB_MODE == 0 || IW'(i) >= rr_ptr)) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && eligible[i]) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
    end

    // Request fields of the selected master. They are latched onto the bus
    // at the grant.
    always_comb begin
        sel_a    = '0;
        sel_r_nw = 1'b1;
        sel_dout = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (winner == IW'(i)) begin
                sel_a    = m_a[i*AW +: AW];
                sel_r_nw = m_r_nw[i];
                sel_dout = m_dout[i*DW +: DW];
            end
        end
    end

    assign wait_done = (wait_cnt == CW'(RD_LAT - 1));

    // -------------------------------------------------------------------------
    // FSM, process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples pre-edge values, whatever the block order.
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM, process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (found) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_WAIT;
            S_WAIT:   if (wait_done) state_nxt = S_ACK;
            S_ACK:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM, process 3: outputs decoded from the state register.
    // The owner keeps its grant from ACCESS through ACK, so m_gnt and m_ack
    // can never name two masters.
    // -------------------------------------------------------------------------
    always_comb begin
        m_gnt  = '0;
        m_ack  = '0;
        bus_en = 1'b0;
        unique case (state)
            S_IDLE:   ;
            S_ACCESS: begin
                m_gnt  = owner_oh;
                bus_en = 1'b1;
            end
            S_WAIT:   m_gnt = owner_oh;
            S_ACK: begin
                m_gnt = owner_oh;
                m_ack = owner_oh;
            end
            default:  ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and arbitration state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            owner      <= '0;
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_owner <= '0;
            wait_cnt   <= '0;
            bus_a      <= '0;
            bus_r_nw   <= 1'b1;
            bus_dout   <= '0;
            m_din      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (lock_valid && !lock_active) begin
                        lock_valid <= 1'b0;
                    end
                    if (found) begin
                        owner    <= winner;
                        bus_a    <= sel_a;
                        bus_r_nw <= sel_r_nw;
                        bus_dout <= sel_dout;
                        // The pointer moves only on a grant. Fixed mode ignores it.
                        rr_ptr   <= (winner == IW'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
                    end
                end
                S_ACCESS: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // The slave data is valid exactly RD_LAT cycles after the
                    // strobe, which is the last WAIT cycle. Writes leave m_din alone.
                    if (wait_done && bus_r_nw) begin
                        m_din <= bus_din;
                    end
                end
                S_ACK: begin
                    if (|(owner_oh & m_lock)) begin
                        lock_valid <= 1'b1;
                        lock_owner <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Structural invariants
    // -------------------------------------------------------------------------
    a_gnt_onehot: assert property (@(posedge clk_in) disable iff (rst_in)
        $onehot0(m_gnt));
    a_ack_onehot: assert property (@(posedge clk_in) disable iff (rst_in)
        $onehot0(m_ack));
    a_ack_owner:  assert property (@(posedge clk_in) disable iff (rst_in)
        (m_ack != '0) |-> (m_ack == m_gnt));
    a_en_granted: assert property (@(posedge clk_in) disable iff (rst_in)
        bus_en |-> (m_gnt != '0));

endmodule
